// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full_subtractor cell, with a start/busy/done handshake.

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (brw_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Result fills from the MSB end so after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {cell_diff, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        brw_d    = brw_q;
        count_d  = count_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = bin;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_next;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                brw_d   = cell_bout;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_next;
                    borrow_d = cell_bout;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes a − b − bin over WIDTH clock cycles, one bit per cycle, LSB first. It sits directly upstream of the team's full_subtractor cell and drives it. Each cycle it presents one operand bit pair and the stored borrow to a single full_subtractor instance, then captures the returned diff and borrow. It is the area-minimal alternative to a WIDTH-wide ripple chain and uses a start/busy/done handshake toward its requester.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  initial borrow-in; sampled on the accepting edge only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking that diff and borrow are valid.
- diff  output  WIDTH  result (a − b − bin) mod 2^WIDTH; registered.
- borrow  output  1  final borrow-out; 1 iff a < b + bin (unsigned).

## Operation
- Internal state:
  - minuend shift register and subtrahend shift register, both shift right.
  - result shift register, filled from the MSB end.
  - 1-bit borrow flop.
  - bit counter of width clog2(WIDTH).
  - FSM with two states, IDLE and RUN.
- Bit cell:
  - One full_subtractor instance.
  - Inputs: a_sr[0], b_sr[0], borrow flop.
  - Outputs: diff bit and borrow-out, which are the only arithmetic in the block.
- IDLE:
  - On start=1, load a_sr←a, b_sr←b, borrow flop←bin and count←0, then go to RUN.
  - On start=0, stay in IDLE.
- RUN, on every edge:
  - Shift the diff bit into the result register MSB.
  - Shift a_sr and b_sr right by one.
  - Borrow flop←cell borrow-out.
  - count←count+1.
- RUN exit:
  - On the edge where count==WIDTH−1, copy the completed result into diff.
  - On the same edge, borrow←cell borrow-out and done←1, and go to IDLE.
- diff and borrow hold their values until the next completion; they never show partial results.
- start while busy=1 is ignored; it is neither queued nor restarts the operation.
- start=1 in the cycle where done=1 is accepted, since the FSM is already in IDLE. This gives back-to-back operation.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset values, applied asynchronously on rst_n=0:
  - FSM in IDLE.
  - busy=0, done=0, diff=0, borrow=0.
  - All internal registers 0.
- Edge numbering: E0 is the edge that samples start=1 in IDLE.
- busy is high from after E0 until edge E_WIDTH, and is low from E_WIDTH onward.
- Edges E1..E_WIDTH each process one bit, LSB first.
- diff, borrow and done=1 are updated at E_WIDTH.
- done is high for exactly the one cycle between E_WIDTH and E_WIDTH+1.
- Latency is WIDTH cycles from the accepting edge to done.
- Maximum throughput is one operation per WIDTH+1 cycles.
- busy and done are never high in the same cycle.
- Reset asserted mid-RUN:
  - Aborts the operation immediately and no done is produced.
  - After rst_n deasserts, the first start is handled normally.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
All scenarios use WIDTH=8.
- a=0x35, b=0x12, bin=0, start for one cycle → busy for 8 cycles, then done pulse with diff=0x23, borrow=0. done is exactly 8 edges after E0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, borrow=1. Repeat with a=0x80, b=0x7F, bin=1 → diff=0x00, borrow=0.
- a=0xFF, b=0xFF, bin=1 → diff=0xFF, borrow=1. Then a=0xFF, b=0x00, bin=0 → diff=0xFF, borrow=0.
- start pulsed at cycle 3 of an operation with different operands → ignored; the first result is unchanged. start held high through done → the next operation starts at E_WIDTH+1 and its done follows 8 edges later.
- rst_n low at bit 4 of a=0x35, b=0x12 → busy, done, diff and borrow drop to 0 immediately and no done appears. A new operation a=0x10, b=0x01, bin=0 then completes with diff=0x0F, borrow=0.
- 10,000 random (a, b, bin) triples with random idle gaps → diff and borrow match the reference model (a − b − bin) mod 256 and borrow=(a < b + bin). Exactly one done per accepted start.
